pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (successor to the fixed IF/ID latch) for any stage boundary.
//  Carries IR, PC and a sideband field with a valid/ready handshake instead of a bare load.
//  A 2-entry skid buffer keeps full throughput under backpressure. Also provides:
//  synchronous flush, per-word NOP injection, and a saturating stall counter.
// PARAMETERS
//  WORD_W     16       width of IR and PC fields
//  SIDE_W     4        width of sideband field (control bits travelling with the instr)
//  NOP_INSTR  16'h0000 encoding driven on out_ir for bubbles (LC-3b BR nzp=000)
//  CNT_W      16       width of stall counter
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous reset, active-low
//  flush        in   1       sync flush: discard all held words this cycle
//  in_valid     in   1       upstream word valid
//  in_ready     out  1       stage can accept; in_fire = in_valid & in_ready
//  inject_nop   in   1       with in_fire: store NOP_INSTR instead of in_ir, mark as bubble
//  in_ir        in   WORD_W  instruction
//  in_pc        in   WORD_W  PC of instruction
//  in_side      in   SIDE_W  sideband
//  out_valid    out  1       head word valid
//  out_ready    in   1       downstream accepts; out_fire = out_valid & out_ready
//  out_ir       out  WORD_W  head instr (NOP_INSTR when empty or injected)
//  out_pc       out  WORD_W  head PC (0 when empty)
//  out_side     out  SIDE_W  head sideband (0 when empty)
//  out_nop      out  1       head is a bubble (empty or injected)
//  occupancy    out  2       words held: 0,1,2
//  stall_cnt    out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state EMPTY, out_valid=0, out_ir=NOP_INSTR, out_pc=0, out_side=0, out_nop=1,
//   occupancy=0, stall_cnt=0, skid regs=0. Reset mid-transfer discards everything; no partial word survives.
//  Storage: main entry (drives out_*) + skid entry. States EMPTY/ONE/FULL == occupancy 0/1/2.
//  in_ready = (state!=FULL) & !flush; depends only on state and flush, never on out_ready.
//  Transitions (flush=0):
//   EMPTY: in_fire -> ONE, main<=in.
//   ONE: in_fire&out_fire -> ONE, main<=in; in_fire&!out_fire -> FULL, skid<=in;
//        !in_fire&out_fire -> EMPTY; else hold.
//   FULL: out_fire -> ONE, main<=skid; else hold. No in_fire possible.
//  flush=1: next state EMPTY from any state, both entries dropped, in_ready=0 this cycle.
//   out_fire in a flush cycle still counts downstream; stall_cnt is not cleared by flush.
//  Latency: in_fire at cycle N -> out_valid at N+1 when EMPTY or ONE-with-out_fire. Throughput 1 word/cycle.
//  Ordering strictly FIFO; a word in skid is never presented before main.
//  inject_nop: captured ir=NOP_INSTR, nop flag=1; pc and side still captured from inputs. Ignored without in_fire.
//  out_nop = !out_valid | main.nop. Empty outputs forced to reset values (NOP_INSTR/0/0).
//  stall_cnt: +1 each cycle out_valid & !out_ready; holds at 2^CNT_W-1.
//  in_valid high while in_ready=0: no capture, upstream must hold data (no drop, no duplicate).
// STRUCTURE
//  lc3b_types: lc3b_word, add constant LC3B_NOP = 16'h0000 (default for NOP_INSTR).
//  Add typedef pipe_state_t enum {PS_EMPTY, PS_ONE, PS_FULL}.
//  Entries built from the existing register module (width-parametrised) with load from the FSM;
//  no new sub-module. FSM, muxes, counter inline.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, out_ir=16'h0000, occupancy=0, in_ready=1 after release.
//  2 Streaming: 8 words ir=16'h1000+i, out_ready=1 -> each appears 1 cycle later, in order, no stalls.
//  3 Backpressure: out_ready=0 after 2 accepts -> occupancy=2, in_ready=0, stall_cnt +1/cycle;
//    release -> words out in order, no loss/dup.
//  4 Flush at FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, offered word not captured.
//  5 inject_nop with in_ir=16'h1234, in_pc=16'h3000 -> out_ir=16'h0000, out_pc=16'h3000, out_nop=1, out_valid=1.
//  6 CNT_W=4, out_ready=0 for 20 cycles with data -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared LC-3b types and pipeline-stage state encoding for pipe_stage_skid.
package pipe_stage_skid_pkg;

  typedef logic [15:0] lc3b_word;

  // BR with nzp=000 never branches, so it is the architectural bubble.
  localparam lc3b_word LC3B_NOP = 16'h0000;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Width-parametrised load register with async reset and synchronous clear.
module pipe_stage_skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage element: clear wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, NOP injection and a saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                WORD_W    = 16,
  parameter int                SIDE_W    = 4,
  parameter logic [WORD_W-1:0] NOP_INSTR = WORD_W'(LC3B_NOP),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inject_nop,
  input  logic [WORD_W-1:0] in_ir,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_ir,
  output logic [WORD_W-1:0] out_pc,
  output logic [SIDE_W-1:0] out_side,
  output logic              out_nop,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Entry layout: {nop, side, pc, ir}
  localparam int ENT_W = 2 * WORD_W + SIDE_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pipe_state_t      state_r, state_nxt_s;
  logic             in_fire_s, out_fire_s;
  logic             main_load_s, skid_load_s;
  logic [ENT_W-1:0] in_ent_s, main_d_s, main_q_s, skid_q_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign in_ready   = (state_r != PS_FULL) && !flush;
  assign out_valid  = (state_r != PS_EMPTY);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;

  assign in_ent_s = inject_nop ? {1'b1, in_side, in_pc, NOP_INSTR}
                               : {1'b0, in_side, in_pc, in_ir};

  // Next-state and entry load decode.
  always_comb begin
    state_nxt_s = state_r;
    main_load_s = 1'b0;
    skid_load_s = 1'b0;
    main_d_s    = in_ent_s;
    if (flush) begin
      state_nxt_s = PS_EMPTY;
    end else begin
      case (state_r)
        PS_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = PS_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = PS_EMPTY;
          end
        end
        PS_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            state_nxt_s = PS_FULL;
            skid_load_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = PS_EMPTY;
          end else begin
            state_nxt_s = PS_ONE;
          end
        end
        PS_FULL: begin
          if (out_fire_s) begin
            state_nxt_s = PS_ONE;
            main_load_s = 1'b1;
            main_d_s    = skid_q_s;
          end else begin
            state_nxt_s = PS_FULL;
          end
        end
        default: begin
          state_nxt_s = PS_EMPTY;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PS_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  pipe_stage_skid_reg #(.WIDTH(ENT_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (main_load_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  pipe_stage_skid_reg #(.WIDTH(ENT_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (skid_load_s),
    .d     (in_ent_s),
    .q     (skid_q_s)
  );

  // An empty stage presents the bubble encoding regardless of stale entry contents.
  assign out_ir    = out_valid ? main_q_s[WORD_W-1:0]                 : NOP_INSTR;
  assign out_pc    = out_valid ? main_q_s[2*WORD_W-1:WORD_W]          : '0;
  assign out_side  = out_valid ? main_q_s[2*WORD_W+SIDE_W-1:2*WORD_W] : '0;
  assign out_nop   = !out_valid || main_q_s[ENT_W-1];
  assign occupancy = state_r;
  assign stall_cnt = stall_cnt_r;

endmodule
